// File: rtl/seg7_scan_if.sv
// Bundle of the signals between a binary-count producer and the 4-digit
// 7-segment scan display.
//
//   value_in : binary value to show (producer -> display)
//   an       : digit enables, active-low, one-hot, an[0] = least significant digit
//   seg      : segments, active-low, seg[0]=a ... seg[6]=g
//   dp       : decimal point, active-low (held off)
//   busy     : binary-to-BCD conversion in progress
//   bcd_out  : committed BCD digits {d3,d2,d1,d0}, 16'hFFFF on overflow
//
// master : the side that supplies value_in and watches the display
// slave  : the display itself
interface seg7_scan_if #(
    parameter int VALUE_W = 14
);
    logic [VALUE_W-1:0] value_in;
    logic [3:0]         an;
    logic [6:0]         seg;
    logic               dp;
    logic               busy;
    logic [15:0]        bcd_out;

    modport master (
        output value_in,
        input  an, seg, dp, busy, bcd_out
    );

    modport slave (
        input  value_in,
        output an, seg, dp, busy, bcd_out
    );
endinterface

// File: rtl/seg7_scan_display.sv
// 4-digit, common-anode, multiplexed 7-segment display driver.
//
// A binary count is converted to BCD by a sequential double-dabble engine
// (one bit per clock). The result is committed to bcd_out in a single edge
// when the conversion finishes, so the scanned digits never show a mix of
// old and new values. A prescaler steps through the four digits, one slot
// of REFRESH_DIV clocks each.
//
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous, active-high reset
//   dsp  : seg7_scan_if.slave
//            value_in (in)  binary value, sampled only while idle
//            an       (out) digit enables, active-low one-hot
//            seg      (out) segments {g..a}, active-low
//            dp       (out) decimal point, held off (1)
//            busy     (out) conversion in progress
//            bcd_out  (out) committed BCD {d3,d2,d1,d0}, 16'hFFFF on overflow
//
// Parameters:
//   VALUE_W     : width of value_in (must match the interface), >= 2
//   REFRESH_DIV : clocks per digit slot, >= 2
//   BLANK_LZ    : 1 = blank leading zeros (digit 0 is never blanked)
module seg7_scan_display #(
    parameter int VALUE_W     = 14,
    parameter int REFRESH_DIV = 100_000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input logic        clk,
    input logic        rst,
    seg7_scan_if.slave dsp
);

    localparam int              PRE_W      = $clog2(REFRESH_DIV);
    localparam int              CNT_W      = $clog2(VALUE_W + 1);
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(VALUE_W - 1);
    localparam logic [31:0]      MAX_DISP  = 32'd9999;
    localparam logic [15:0]      OVF_BCD   = 16'hFFFF;
    localparam logic [6:0]       SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------

    // Double-dabble correction: any BCD nibble of 5 or more gets +3 so that
    // the following left shift carries correctly into the next decade.
    function automatic logic [15:0] dd_adjust(input logic [15:0] b);
        logic [15:0] r;
        r = b;
        for (int i = 0; i < 4; i++) begin
            if (b[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = b[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // Active-low {g,f,e,d,c,b,a}. F is the overflow dash; A-E cannot be
    // produced by the converter and are shown blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hF:    s = 7'h3F;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // ------------------------------------------------------------------
    // Conversion state
    // ------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [VALUE_W-1:0] shadow_q;
    logic               first_q;
    logic [VALUE_W-1:0] bin_q;
    logic [15:0]        bcd_q;
    logic [15:0]        bcd_adj;
    logic [CNT_W-1:0]   shift_cnt_q;
    logic               busy_q;
    logic [15:0]        bcd_out_q;
    logic               start;
    logic               ovf;

    // A new conversion is needed after reset (nothing committed yet) or
    // whenever the input differs from the last value converted.
    assign start   = first_q || (dsp.value_in != shadow_q);
    assign bcd_adj = dd_adjust(bcd_q);
    assign ovf     = (32'(shadow_q) > MAX_DISP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (shift_cnt_q == SHIFT_LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q    <= '0;
            first_q     <= 1'b1;
            bin_q       <= '0;
            bcd_q       <= '0;
            shift_cnt_q <= '0;
            busy_q      <= 1'b0;
            bcd_out_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        shadow_q    <= dsp.value_in;
                        bin_q       <= dsp.value_in;
                        bcd_q       <= '0;
                        first_q     <= 1'b0;
                        busy_q      <= 1'b1;
                        shift_cnt_q <= '0;
                    end
                end
                SHIFT: begin
                    // {bcd, bin} <<= 1 after the per-nibble correction
                    bcd_q       <= {bcd_adj[14:0], bin_q[VALUE_W-1]};
                    bin_q       <= {bin_q[VALUE_W-2:0], 1'b0};
                    shift_cnt_q <= shift_cnt_q + 1'b1;
                end
                DONE: begin
                    // Single-edge commit keeps the displayed digits coherent.
                    bcd_out_q <= ovf ? OVF_BCD : bcd_q;
                    busy_q    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Digit scan
    // ------------------------------------------------------------------
    logic [PRE_W-1:0] prescaler_q;
    logic [1:0]       digit_idx_q;
    logic [3:0]       an_q;
    logic [6:0]       seg_q;
    logic [3:0]       cur_nib;
    logic             upper_zero;
    logic [6:0]       seg_next;

    // Pattern for the digit about to be shown. upper_zero is true when this
    // digit and every more significant digit are zero; digit 0 never blanks.
    always_comb begin
        cur_nib    = bcd_out_q[{digit_idx_q, 2'b00} +: 4];
        upper_zero = 1'b0;
        case (digit_idx_q)
            2'd1:    upper_zero = (bcd_out_q[15:4]  == 12'h000);
            2'd2:    upper_zero = (bcd_out_q[15:8]  == 8'h00);
            2'd3:    upper_zero = (bcd_out_q[15:12] == 4'h0);
            default: upper_zero = 1'b0;
        endcase
        seg_next = seg_decode(cur_nib);
        if (BLANK_LZ && upper_zero && (bcd_out_q != OVF_BCD)) begin
            seg_next = SEG_BLANK;
        end
    end

    // an and seg are loaded together on the wrap edge, so the enable and the
    // pattern always change in the same cycle and only one digit is ever on.
    // Until the first wrap after reset everything stays dark.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler_q <= '0;
            digit_idx_q <= 2'd0;
            an_q        <= 4'b1111;
            seg_q       <= SEG_BLANK;
        end else if (prescaler_q == PRE_LAST) begin
            prescaler_q <= '0;
            digit_idx_q <= digit_idx_q + 2'd1;
            an_q        <= ~(4'b0001 << digit_idx_q);
            seg_q       <= seg_next;
        end else begin
            prescaler_q <= prescaler_q + 1'b1;
        end
    end

    assign dsp.an      = an_q;
    assign dsp.seg     = seg_q;
    assign dsp.dp      = 1'b1;
    assign dsp.busy    = busy_q;
    assign dsp.bcd_out = bcd_out_q;

endmodule
